br_regfile: RTL and testbench



---
 rtl/br_regfile_if.sv | 16 +
 rtl/br_regfile.sv | 41 ++++
 tb/tb_br_regfile.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/br_regfile_if.sv
// Operand read / writeback bus between decode, ALU and the integer register bank.
interface br_regfile_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [WIDTH-1:0]  wd3;
  logic              we;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;

  modport master (output a1, a2, a3, wd3, we, input rd1, rd2);
  modport slave  (input a1, a2, a3, wd3, we, output rd1, rd2);
endinterface

// File: rtl/br_regfile.sv
// Integer register bank: 2**ADDR_W x WIDTH, two combinational reads, one write, x0 reads zero.
// Optional macro BR_BYPASS_EN forwards same-cycle write data onto matching read ports.
module br_regfile #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  br_regfile_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (bus.we && (bus.a3 != '0)) begin
      regs_q[bus.a3] <= bus.wd3;
    end
  end

  always_comb begin
    rd1_c = (bus.a1 == '0) ? '0 : regs_q[bus.a1];
    rd2_c = (bus.a2 == '0) ? '0 : regs_q[bus.a2];
`ifdef BR_BYPASS_EN
    if (bus.we && (bus.a3 != '0) && (bus.a1 == bus.a3)) rd1_c = bus.wd3;
    if (bus.we && (bus.a3 != '0) && (bus.a2 == bus.a3)) rd2_c = bus.wd3;
`endif
    if (rst) begin
      rd1_c = '0;
      rd2_c = '0;
    end
  end

  assign bus.rd1 = rd1_c;
  assign bus.rd2 = rd2_c;
endmodule

// File: tb/tb_br_regfile.sv
// Directed bench for br_regfile: expected read data queued when stimulus is driven, popped when sampled.
module tb_br_regfile;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  br_regfile_if #(.WIDTH(32), .ADDR_W(5)) bus ();

  br_regfile #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(string t, logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check(logic [31:0] obs);
    logic [31:0] e;
    string       t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h required=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h required=%h", t, obs, e);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.we  = 1'b0;
    bus.a1  = '0;
    bus.a2  = '0;
    bus.a3  = 'x;
    bus.wd3 = 'x;
    #12;
    rst = 1'b0;
    #2;

    bus.a1 = 5'd3; bus.a2 = 5'd4; #1;
    expect_val("reset_rd1_a3", 32'h0); check(bus.rd1);
    expect_val("reset_rd2_a4", 32'h0); check(bus.rd2);
    for (int i = 0; i < 32; i++) begin
      bus.a1 = 5'(i); #1;
      expect_val($sformatf("reset_reg%0d", i), 32'h0); check(bus.rd1);
    end

    bus.we = 1'b0; bus.a3 = 5'd3; bus.wd3 = 32'd123;
    tick(); tick();
    bus.a1 = 5'd3; #1;
    expect_val("we0_no_write", 32'h0); check(bus.rd1);

    bus.we = 1'b1; bus.a3 = 5'd3; bus.wd3 = 32'd123;
    tick(); bus.we = 1'b0; #1;
    expect_val("write_reg3", 32'd123); check(bus.rd1);
    bus.we = 1'b1; bus.a3 = 5'd4;
    tick(); bus.we = 1'b0; bus.a2 = 5'd4; #1;
    expect_val("write_reg4", 32'd123); check(bus.rd2);
    bus.a3 = 5'd2; bus.wd3 = 32'd555;
    tick(); bus.a1 = 5'd2; #1;
    expect_val("we0_reg2", 32'h0); check(bus.rd1);

    bus.we = 1'b1; bus.a3 = 5'd0; bus.wd3 = 32'hDEAD_BEEF;
    tick(); bus.we = 1'b0; bus.a1 = 5'd0; bus.a2 = 5'd0; #1;
    expect_val("x0_rd1", 32'h0); check(bus.rd1);
    expect_val("x0_rd2", 32'h0); check(bus.rd2);

    bus.a1 = 5'd5; bus.a2 = 5'd5; bus.a3 = 5'd5; bus.wd3 = 32'd77; bus.we = 1'b1; #1;
`ifdef BR_BYPASS_EN
    expect_val("same_cycle_rd1", 32'd77); check(bus.rd1);
    expect_val("same_cycle_rd2", 32'd77); check(bus.rd2);
`else
    expect_val("same_cycle_rd1", 32'h0); check(bus.rd1);
    expect_val("same_cycle_rd2", 32'h0); check(bus.rd2);
`endif
    tick(); bus.we = 1'b0; #1;
    expect_val("after_edge_rd1", 32'd77); check(bus.rd1);
    expect_val("after_edge_rd2", 32'd77); check(bus.rd2);

    bus.we = 1'b1; bus.a3 = 5'd31; bus.wd3 = 32'hFFFF_FFFF;
    tick(); bus.we = 1'b0; bus.a1 = 5'd31; #1;
    expect_val("reg31_written", 32'hFFFF_FFFF); check(bus.rd1);
    bus.we = 1'b1; bus.a3 = 5'd7; bus.wd3 = 32'd55; bus.a2 = 5'd7;
    #1; rst = 1'b1; #1;
    expect_val("async_rst_rd1", 32'h0); check(bus.rd1);
    expect_val("async_rst_rd2", 32'h0); check(bus.rd2);
    tick();
    rst = 1'b0; bus.we = 1'b0; #1;
    expect_val("rst_drops_write", 32'h0); check(bus.rd2);
    expect_val("rst_clears_reg31", 32'h0); check(bus.rd1);

    for (int i = 1; i < 32; i++) begin
      bus.we = 1'b1; bus.a3 = 5'(i); bus.wd3 = pat(i);
      tick();
    end
    bus.we = 1'b0; bus.a3 = 'x; bus.wd3 = 'x;
    for (int i = 0; i < 32; i++) begin
      bus.a1 = 5'(i); bus.a2 = 5'(31 - i); #1;
      expect_val($sformatf("bank_rd1_%0d", i), (i == 0) ? 32'h0 : pat(i));
      check(bus.rd1);
      expect_val($sformatf("bank_rd2_%0d", 31 - i), (i == 31) ? 32'h0 : pat(31 - i));
      check(bus.rd2);
    end
    tick();
    bus.a1 = 5'd9; bus.a2 = 5'd9; #1;
    expect_val("same_addr_rd1", pat(9)); check(bus.rd1);
    expect_val("same_addr_rd2", pat(9)); check(bus.rd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
